wb_master_queue: RTL

WB_MASTER_QUEUE -- requirements
Module: wb_master_queue

---
 rtl/wb_master_pkg.sv | 16 +
 rtl/wb_master_queue_if.sv | 42 ++++
 rtl/wb_master_fifo.sv | 46 ++++
 rtl/wb_master_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the queued Wishbone master: FSM states and response codes.
// GAP exists only when WB_MASTER_RETRY_EN is defined.
package wb_master_pkg;

`ifdef WB_MASTER_RETRY_EN
    typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_e;
`else
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
`endif

    localparam logic [1:0] RSP_OK        = 2'b00;
    localparam logic [1:0] RSP_ERR       = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT   = 2'b10;
    localparam logic [1:0] RSP_RETRY_EXH = 2'b11;

endpackage

// File: rtl/wb_master_queue_if.sv
// Command, response and Wishbone signals of wb_master_queue; master = queue side, slave = environment side.
interface wb_master_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_adr;
    logic [DATA_WIDTH-1:0] cmd_dat;
    logic [SEL_WIDTH-1:0]  cmd_sel;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_dat;
    logic [1:0]            rsp_status;

    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] din;
    logic                  ack;
    logic                  err;
    logic                  rty;
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, din, ack, err, rty,
        output cmd_ready, rsp_valid, rsp_dat, rsp_status, adr, dout, cyc, stb, we, sel, busy
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, din, ack, err, rty,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_status, adr, dout, cyc, stb, we, sel, busy
    );

endinterface

// File: rtl/wb_master_fifo.sv
// Synchronous FIFO, DEPTH a power of two; push ignored when full, pop ignored when empty.
// Read data is the head entry, valid combinationally whenever empty_o is low.
module wb_master_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_master_queue.sv
// Queued Wishbone master: FIFO of commands, one bus transaction at a time, one held response.
// WB_MASTER_RETRY_EN enables re-issue on rty (GAP state, retry counter); otherwise rty acts as err.
module wb_master_queue
    import wb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic              clk,
    input  logic              rst,
    wb_master_queue_if.master bus
);
    localparam int SEL_WIDTH         = DATA_WIDTH / 8;
    localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  sel;
    } cmd_t;

    cmd_t   fifo_in, fifo_out;
    logic   full, empty, pop;

    state_e                state_q;
    logic                  cyc_q, stb_q, we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_dat_q;
    logic [1:0]            rsp_status_q;
    logic [15:0]           tmo_q, tmo_d;

    logic                  done_d, fail;
    logic [1:0]            status_d;
    logic [DATA_WIDTH-1:0] dat_d;

`ifdef WB_MASTER_RETRY_EN
    logic [3:0] retry_q;
    logic       retry_go_d;
    assign fail = bus.err;
`else
    assign fail = bus.err || bus.rty;
`endif

    assign fifo_in = '{we: bus.cmd_we, adr: bus.cmd_adr, dat: bus.cmd_dat, sel: bus.cmd_sel};

    wb_master_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cmd_valid),
        .pop_i   (pop),
        .wdata_i (fifo_in),
        .rdata_o (fifo_out),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.cmd_ready  = !full;
    assign pop            = (state_q == IDLE) && !empty && !rsp_valid_q;
    assign bus.cyc        = cyc_q;
    assign bus.stb        = stb_q;
    assign bus.we         = we_q;
    assign bus.adr        = adr_q;
    assign bus.dout       = dout_q;
    assign bus.sel        = sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_dat    = rsp_dat_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.busy       = !empty || (state_q != IDLE) || rsp_valid_q;

    // Termination decode for the BUS state, priority err > rty > ack > timeout.
    always_comb begin
        done_d   = 1'b0;
        status_d = RSP_OK;
        dat_d    = '0;
        tmo_d    = tmo_q + 16'd1;
`ifdef WB_MASTER_RETRY_EN
        retry_go_d = 1'b0;
`endif
        if (fail) begin
            done_d   = 1'b1;
            status_d = RSP_ERR;
        end
`ifdef WB_MASTER_RETRY_EN
        else if (bus.rty) begin
            if (retry_q == 4'(MAX_RETRY)) begin
                done_d   = 1'b1;
                status_d = RSP_RETRY_EXH;
            end else begin
                retry_go_d = 1'b1;
            end
        end
`endif
        else if (bus.ack) begin
            done_d = 1'b1;
            dat_d  = we_q ? '0 : bus.din;
        end else if (tmo_d == TMO_LIM) begin
            done_d   = 1'b1;
            status_d = RSP_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dout_q       <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= RSP_OK;
            tmo_q        <= '0;
`ifdef WB_MASTER_RETRY_EN
            retry_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= BUS;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= fifo_out.we;
                        adr_q   <= fifo_out.adr;
                        dout_q  <= fifo_out.dat;
                        sel_q   <= fifo_out.sel;
                        tmo_q   <= '0;
`ifdef WB_MASTER_RETRY_EN
                        retry_q <= '0;
`endif
                    end
                end
                BUS: begin
                    if (done_d) begin
                        state_q      <= RESP;
                        cyc_q        <= 1'b0;
                        stb_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= status_d;
                        rsp_dat_q    <= dat_d;
                    end
`ifdef WB_MASTER_RETRY_EN
                    else if (retry_go_d) begin
                        state_q <= GAP;
                        stb_q   <= 1'b0;
                        retry_q <= retry_q + 4'd1;
                        tmo_q   <= '0;
                    end
`endif
                    else begin
                        tmo_q <= tmo_d;
                    end
                end
`ifdef WB_MASTER_RETRY_EN
                GAP: begin
                    state_q <= BUS;
                    stb_q   <= 1'b1;
                end
`endif
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
